trap_ctrl: RTL and testbench

Trap sequencer between the write-back stage and the machine CSR file. Accepts a retiring exception or `mret` from WB, produces the one-cycle `mcause`/`mtval`/`mepc` write strobes consumed by the CSR file, flushes the pipeline for a fixed drain period, then hands a redirect PC to instruction fetch over a valid/ready handshake. Exception targets come from the CSR file's `mtvec` read port; `mret` targets come from its `mepc` read port.

---
 rtl/trap_ctrl_if.sv | 49 ++++
 rtl/trap_ctrl.sv | 107 ++++++++++
 tb/tb_trap_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_if
// Purpose  : WB / CSR-file / fetch signal bundle for the trap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            wb_valid_i;
    logic [XLEN-1:0] wb_pc_i;
    logic            wb_excp_i;
    logic [3:0]      wb_excp_code_i;
    logic [XLEN-1:0] wb_excp_tval_i;
    logic            wb_mret_i;
    logic [XLEN-1:0] mtvec_rdata_i;
    logic [XLEN-1:0] mepc_rdata_i;
    logic            mcause_wen_o;
    logic [XLEN-1:0] mcause_wdata_o;
    logic            mtval_wen_o;
    logic [XLEN-1:0] mtval_wdata_o;
    logic            mepc_wen_o;
    logic [XLEN-1:0] mepc_wdata_o;
    logic            flush_o;
    logic            busy_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            redirect_ready_i;
    logic [31:0]     trap_cnt_o;

    // Environment side: drives WB, CSR read data and fetch ready.
    modport master (
        output wb_valid_i, wb_pc_i, wb_excp_i, wb_excp_code_i, wb_excp_tval_i,
               wb_mret_i, mtvec_rdata_i, mepc_rdata_i, redirect_ready_i,
        input  mcause_wen_o, mcause_wdata_o, mtval_wen_o, mtval_wdata_o,
               mepc_wen_o, mepc_wdata_o, flush_o, busy_o, redirect_valid_o,
               redirect_pc_o, trap_cnt_o
    );

    // Sequencer side.
    modport slave (
        input  wb_valid_i, wb_pc_i, wb_excp_i, wb_excp_code_i, wb_excp_tval_i,
               wb_mret_i, mtvec_rdata_i, mepc_rdata_i, redirect_ready_i,
        output mcause_wen_o, mcause_wdata_o, mtval_wen_o, mtval_wdata_o,
               mepc_wen_o, mepc_wdata_o, flush_o, busy_o, redirect_valid_o,
               redirect_pc_o, trap_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Exception/mret sequencer: CSR commit, pipeline drain, redirect.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    trap_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic            accept_excp;
    logic            accept_mret;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] target;
    logic [3:0]      code;
    logic [3:0]      cnt;
    logic [31:0]     trap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Exception wins over mret; WB is only looked at while idle.
    always_comb begin
        state_nxt   = state;
        accept_excp = 1'b0;
        accept_mret = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wb_valid_i && bus.wb_excp_i) begin
                    accept_excp = 1'b1;
                    state_nxt   = COMMIT;
                end else if (bus.wb_valid_i && bus.wb_mret_i) begin
                    accept_mret = 1'b1;
                    state_nxt   = FLUSH;
                end
            end
            COMMIT:   state_nxt = FLUSH;
            FLUSH:    if (cnt == 4'd0) state_nxt = REDIRECT;
            REDIRECT: if (bus.redirect_ready_i) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            tval     <= '0;
            code     <= '0;
            target   <= '0;
            cnt      <= '0;
            trap_cnt <= '0;
        end else begin
            if (accept_excp) begin
                pc     <= bus.wb_pc_i;
                tval   <= bus.wb_excp_tval_i;
                code   <= bus.wb_excp_code_i;
                target <= bus.mtvec_rdata_i;
            end
            if (accept_mret) begin
                target <= bus.mepc_rdata_i;
            end
            // mret skips COMMIT, so it loads the drain counter on acceptance.
            if (accept_mret || state == COMMIT) begin
                cnt <= CNT_LOAD;
            end else if (state == FLUSH && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == COMMIT) begin
                trap_cnt <= trap_cnt + 32'd1;
            end
        end
    end

    assign bus.mcause_wen_o     = (state == COMMIT);
    assign bus.mtval_wen_o      = (state == COMMIT);
    assign bus.mepc_wen_o       = (state == COMMIT);
    assign bus.mcause_wdata_o   = {{(XLEN-4){1'b0}}, code};
    assign bus.mtval_wdata_o    = tval;
    assign bus.mepc_wdata_o     = {pc[XLEN-1:2], 2'b00};
    assign bus.flush_o          = (state != IDLE);
    assign bus.busy_o           = (state != IDLE);
    assign bus.redirect_valid_o = (state == REDIRECT);
    assign bus.redirect_pc_o    = target;
    assign bus.trap_cnt_o       = trap_cnt;
endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed + randomized bench for trap_ctrl against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;
    localparam int XLEN = 32;
    localparam int F    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if #(.XLEN(XLEN)) bus ();
    trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(F)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Model: a trap is a timeline of absolute cycle numbers, not a state machine.
    int          cyc;
    bit          m_active;
    int          m_commit_at;
    int          m_redir_from;
    logic [31:0] m_pc, m_tval, m_target, m_cnt;
    logic [3:0]  m_code;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_commit_at = -1; m_redir_from = 0;
        m_pc = '0; m_tval = '0; m_target = '0; m_cnt = '0; m_code = '0;
    endtask

    task automatic check_outputs();
        bit strobe, rv;
        strobe = m_active && (cyc == m_commit_at);
        rv     = m_active && (cyc >= m_redir_from);
        check_val("mcause_wen", 32'(bus.mcause_wen_o), 32'(strobe));
        check_val("mtval_wen", 32'(bus.mtval_wen_o), 32'(strobe));
        check_val("mepc_wen", 32'(bus.mepc_wen_o), 32'(strobe));
        check_val("mcause_wdata", bus.mcause_wdata_o, 32'(m_code));
        check_val("mtval_wdata", bus.mtval_wdata_o, m_tval);
        check_val("mepc_wdata", bus.mepc_wdata_o, m_pc & 32'hFFFF_FFFC);
        check_val("flush", 32'(bus.flush_o), 32'(m_active));
        check_val("busy", 32'(bus.busy_o), 32'(m_active));
        check_val("redirect_valid", 32'(bus.redirect_valid_o), 32'(rv));
        check_val("redirect_pc", bus.redirect_pc_o, m_target);
        check_val("trap_cnt", bus.trap_cnt_o, m_cnt);
    endtask

    task automatic drive(input bit v, input bit e, input bit m, input logic [3:0] code,
                         input logic [31:0] pc, input logic [31:0] tval,
                         input logic [31:0] mtvec, input logic [31:0] mepc, input bit rdy);
        bus.wb_valid_i = v;        bus.wb_excp_i = e;          bus.wb_mret_i = m;
        bus.wb_excp_code_i = code; bus.wb_pc_i = pc;           bus.wb_excp_tval_i = tval;
        bus.mtvec_rdata_i = mtvec; bus.mepc_rdata_i = mepc;    bus.redirect_ready_i = rdy;
    endtask

    // One cycle: check outputs, apply inputs, advance the model, cross the edge.
    task automatic step(input bit v, input bit e, input bit m, input logic [3:0] code,
                        input logic [31:0] pc, input logic [31:0] tval,
                        input logic [31:0] mtvec, input logic [31:0] mepc, input bit rdy);
        check_outputs();
        drive(v, e, m, code, pc, tval, mtvec, mepc, rdy);
        if (!m_active) begin
            if (v && e) begin
                m_active = 1'b1; m_commit_at = cyc + 1; m_redir_from = cyc + 2 + F;
                m_pc = pc; m_tval = tval; m_code = code; m_target = mtvec;
            end else if (v && m) begin
                m_active = 1'b1; m_commit_at = -1; m_redir_from = cyc + 1 + F;
                m_target = mepc;
            end
        end else begin
            if (cyc == m_commit_at) m_cnt = m_cnt + 32'd1;
            if (cyc >= m_redir_from && rdy) m_active = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy, input logic [31:0] mtvec);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 32'd0, 32'd0, mtvec, 32'h0, rdy);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        drive(0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        drive(0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        rst = 1'b1;
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic exception with 5 cycles of fetch backpressure.
        step(1, 1, 0, 4'd2, 32'h104, 32'hDEAD, 32'd40, 32'h0, 0);
        idle(8, 0, 32'd40);
        step(0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd40, 32'h0, 1);
        idle(1, 0, 32'd40);
        check_val("basic_trap_cnt", bus.trap_cnt_o, 32'd1);

        // mret with fetch ready held high.
        step(1, 0, 1, 4'd0, 32'h0, 32'h0, 32'd40, 32'h200, 1);
        idle(5, 1, 32'd40);

        // Exception and mret together, then WB exceptions while busy.
        step(1, 1, 1, 4'd5, 32'h300, 32'h1, 32'd40, 32'h200, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 4'd7, 32'h500, 32'h2, 32'd40, 32'h0, 0);
        idle(2, 1, 32'd40);

        // Exception without valid is ignored.
        step(0, 1, 1, 4'd3, 32'h600, 32'h3, 32'd40, 32'h0, 1);
        idle(2, 1, 32'd40);

        // Misaligned PC, and mtvec changing after acceptance.
        step(1, 1, 0, 4'd4, 32'h107, 32'h4, 32'd40, 32'h0, 0);
        idle(4, 0, 32'd80);
        idle(2, 1, 32'd80);

        // Reset during FLUSH.
        step(1, 1, 0, 4'd6, 32'h800, 32'h5, 32'd40, 32'h0, 0);
        idle(2, 0, 32'd40);
        do_reset();
        idle(2, 1, 32'd40);

        // Counter wrap: preload near the top, then two exceptions.
        force dut.trap_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.trap_cnt;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 0, 4'd9, 32'h900, 32'h6, 32'd40, 32'h0, 1);
            idle(F + 2, 1, 32'd40);
        end
        check_val("wrap_trap_cnt", bus.trap_cnt_o, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 4'($urandom), $urandom, $urandom, $urandom, $urandom,
                 $urandom_range(0, 4) < 2);
        end
        idle(F + 4, 1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
